// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Sequencer for the HI/LO special registers. Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO
// requests from execute. Multiplies finish after a fixed latency. Divides use a
// 32-step radix-2 restoring algorithm. The front of the pipeline is stalled while
// an operation is in flight. Results leave as registered one-cycle HI/LO write
// pulses.

module hilo_muldiv_ctrl #(
   parameter int MUL_LAT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   input  logic [2:0]  i_req_op,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   input  logic        i_flush,
   output logic        o_req_ready,
   output logic        o_stall,
   output logic        o_hi_write,
   output logic        o_lo_write,
   output logic [31:0] o_hi_data,
   output logic [31:0] o_lo_data
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // The MUL state lasts MUL_LAT-1 cycles, so the count runs from 0 to MUL_LAT-2.
   // With MUL_LAT=1 the MUL state is never entered, so this value goes unused.
   localparam logic [4:0] MUL_LAST = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;
   localparam logic [4:0] DIV_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [4:0]  r_count;
   logic [4:0]  w_count_next;

   // Operands latched at acceptance. r_op_a also keeps the raw dividend for the
   // divide-by-zero result.
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic        r_signed;

   // Divider state: partial remainder, dividend/quotient shift register, divisor.
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvsr;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_div0;

   logic        r_hi_write;
   logic        r_lo_write;
   logic [31:0] r_hi_data;
   logic [31:0] r_lo_data;
   logic        w_hi_write_next;
   logic        w_lo_write_next;
   logic [31:0] w_hi_data_next;
   logic [31:0] w_lo_data_next;

   logic        w_idle;
   logic        w_accept;
   logic        w_op_signed_div;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [63:0] w_prod_reg;
   logic [63:0] w_prod_req;
   logic [32:0] w_shift;
   logic        w_ge;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_q_final;
   logic [31:0] w_r_final;

   // Extend both operands to 64 bits (sign- or zero-extended). The low 64 bits of
   // the product are then correct for either signedness.
   function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = s ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   assign w_idle          = (r_state == ST_IDLE);
   assign w_accept        = w_idle & i_req_valid & ~i_flush & (i_req_op <= OP_MTLO);
   assign o_req_ready     = w_idle;
   assign o_stall         = ~w_idle | (w_idle & i_req_valid & ~i_flush & (i_req_op <= OP_DIVU));

   assign w_op_signed_div = (i_req_op == OP_DIV);
   assign w_a_mag         = (w_op_signed_div & i_req_a[31]) ? -i_req_a : i_req_a;
   assign w_b_mag         = (w_op_signed_div & i_req_b[31]) ? -i_req_b : i_req_b;

   assign w_prod_reg      = f_mul(r_op_a, r_op_b, r_signed);
   assign w_prod_req      = f_mul(i_req_a, i_req_b, i_req_op == OP_MULT);

   // One restoring step. Shift the next dividend bit into a 33-bit partial
   // remainder, then subtract the divisor if it fits. The result is always below
   // the divisor, so it fits back into 32 bits.
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_ge      = (w_shift >= {1'b0, r_dvsr});
   assign w_rem_nxt = w_ge ? (w_shift[31:0] - r_dvsr) : w_shift[31:0];
   assign w_quo_nxt = {r_quo[30:0], w_ge};

   // Sign fix on the last step. The quotient is negated when operand signs differ.
   // The remainder follows the dividend's sign.
   assign w_q_final = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
   assign w_r_final = r_div0 ? r_op_a        : (r_neg_r ? -w_rem_nxt : w_rem_nxt);

   // State and iteration counter register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_count <= 5'd0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Next-state logic. Result pulses are produced on the edge that leaves MUL or
   // DIV, or on the accept edge for MTHI/MTLO and single-cycle multiplies.
   always_comb begin
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_hi_write_next = 1'b0;
      w_lo_write_next = 1'b0;
      w_hi_data_next  = r_hi_data;
      w_lo_data_next  = r_lo_data;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (i_req_op)
                  OP_MULT, OP_MULTU: begin
                     if (MUL_LAT == 1) begin
                        w_hi_write_next = 1'b1;
                        w_lo_write_next = 1'b1;
                        w_hi_data_next  = w_prod_req[63:32];
                        w_lo_data_next  = w_prod_req[31:0];
                     end else begin
                        w_state_next = ST_MUL;
                        w_count_next = 5'd0;
                     end
                  end
                  OP_DIV, OP_DIVU: begin
                     w_state_next = ST_DIV;
                     w_count_next = 5'd0;
                  end
                  OP_MTHI: begin
                     w_hi_write_next = 1'b1;
                     w_hi_data_next  = i_req_a;
                  end
                  OP_MTLO: begin
                     w_lo_write_next = 1'b1;
                     w_lo_data_next  = i_req_a;
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_MUL: begin
            if (i_flush) begin
               w_state_next = ST_IDLE;
               w_count_next = 5'd0;
            end else if (r_count == MUL_LAST) begin
               w_state_next    = ST_IDLE;
               w_count_next    = 5'd0;
               w_hi_write_next = 1'b1;
               w_lo_write_next = 1'b1;
               w_hi_data_next  = w_prod_reg[63:32];
               w_lo_data_next  = w_prod_reg[31:0];
            end else begin
               w_count_next = r_count + 5'd1;
            end
         end
         ST_DIV: begin
            if (i_flush) begin
               w_state_next = ST_IDLE;
               w_count_next = 5'd0;
            end else if (r_count == DIV_LAST) begin
               w_state_next    = ST_IDLE;
               w_count_next    = 5'd0;
               w_hi_write_next = 1'b1;
               w_lo_write_next = 1'b1;
               w_hi_data_next  = w_r_final;
               w_lo_data_next  = w_q_final;
            end else begin
               w_count_next = r_count + 5'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_count_next = 5'd0;
         end
      endcase
   end

   // Operand capture on acceptance, then one divide step per cycle in DIV.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_op_a   <= 32'd0;
         r_op_b   <= 32'd0;
         r_signed <= 1'b0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_dvsr   <= 32'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
      end else if (w_accept) begin
         r_op_a   <= i_req_a;
         r_op_b   <= i_req_b;
         r_signed <= (i_req_op == OP_MULT);
         r_rem    <= 32'd0;
         r_quo    <= w_a_mag;
         r_dvsr   <= w_b_mag;
         r_neg_q  <= w_op_signed_div & (i_req_a[31] ^ i_req_b[31]);
         r_neg_r  <= w_op_signed_div & i_req_a[31];
         r_div0   <= (i_req_b == 32'd0);
      end else if (r_state == ST_DIV) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
      end
   end

   // Registered write strobes and data. The data registers keep their last value.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hi_write <= 1'b0;
         r_lo_write <= 1'b0;
         r_hi_data  <= 32'd0;
         r_lo_data  <= 32'd0;
      end else begin
         r_hi_write <= w_hi_write_next;
         r_lo_write <= w_lo_write_next;
         r_hi_data  <= w_hi_data_next;
         r_lo_data  <= w_lo_data_next;
      end
   end

   assign o_hi_write = r_hi_write;
   assign o_lo_write = r_lo_write;
   assign o_hi_data  = r_hi_data;
   assign o_lo_data  = r_lo_data;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl
// Bench for the HI/LO multiply/divide sequencer. Each expected result is queued
// when its request is driven. It is popped and compared when the write pulse
// appears.

module tb_hilo_muldiv_ctrl;

   localparam int MUL_LAT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic [2:0]  reqOp;
   logic [31:0] reqA;
   logic [31:0] reqB;
   logic        flush;
   logic        reqReady;
   logic        stall;
   logic        hiWrite;
   logic        loWrite;
   logic [31:0] hiData;
   logic [31:0] loData;

   typedef struct {
      logic        hw;
      logic        lw;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   exp_t        scb[$];
   int          passCount = 0;
   int          checkCount = 0;
   logic        issStall;
   logic        issReady;
   logic        obsHw;
   logic        obsLw;
   logic [31:0] obsHi;
   logic [31:0] obsLo;
   int          lat;
   int          stallCnt;
   logic        stallAtPulse;

   hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req_valid (reqValid),
      .i_req_op    (reqOp),
      .i_req_a     (reqA),
      .i_req_b     (reqB),
      .i_flush     (flush),
      .o_req_ready (reqReady),
      .o_stall     (stall),
      .o_hi_write  (hiWrite),
      .o_lo_write  (loWrite),
      .o_hi_data   (hiData),
      .o_lo_data   (loData)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCount, checkCount);
      $fatal(1, "[TB] watchdog");
   end

   // Reference results, computed with wide integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sa;
      longint      sbv;
      longint      q;
      longint      r;
      e.hw  = 1'b1;
      e.lw  = 1'b1;
      e.hi  = 32'd0;
      e.lo  = 32'd0;
      e.lat = MUL_LAT;
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2, 3'd3: begin
            e.lat = 33;
            if (b == 32'd0) begin
               e.lo = 32'hFFFF_FFFF;
               e.hi = a;
            end else begin
               if (op == 3'd3) begin
                  sa  = longint'({32'd0, a});
                  sbv = longint'({32'd0, b});
               end
               q = sa / sbv;
               r = sa % sbv;
               e.lo = q[31:0];
               e.hi = r[31:0];
            end
         end
         3'd4: begin e.lw = 1'b0; e.hi = a; e.lat = 1; end
         default: begin e.hw = 1'b0; e.lo = a; e.lat = 1; end
      endcase
      return e;
   endfunction

   // Present a request for one cycle and capture what the DUT shows in that cycle.
   task automatic issueReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      reqValid = 1'b1; reqOp = op; reqA = a; reqB = b; flush = 1'b0;
      #1;
      issStall = stall; issReady = reqReady;
      obsHw = hiWrite; obsLw = loWrite; obsHi = hiData; obsLo = loData;
   endtask

   // Idle the inputs until a write strobe appears or the limit expires (lat=0).
   task automatic waitPulse(input int limit);
      lat = 0; stallCnt = 0; stallAtPulse = 1'b1; obsHw = 1'b0; obsLw = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         reqValid = 1'b0; flush = 1'b0;
         #1;
         if (hiWrite || loWrite) begin
            lat = k; stallAtPulse = stall;
            obsHw = hiWrite; obsLw = loWrite; obsHi = hiData; obsLo = loData;
            break;
         end
         if (stall) stallCnt++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; reqValid = 1'b0; flush = 1'b0; reqOp = 3'd0; reqA = 32'd0; reqB = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      checkCount++; if (hiWrite !== 1'b0) $display("[TB] FAIL reset_hiwrite got %b want 0", hiWrite); else passCount++;
      checkCount++; if (loWrite !== 1'b0) $display("[TB] FAIL reset_lowrite got %b want 0", loWrite); else passCount++;
      checkCount++; if (hiData !== 32'd0) $display("[TB] FAIL reset_hidata got %h want 0", hiData); else passCount++;
      checkCount++; if (loData !== 32'd0) $display("[TB] FAIL reset_lodata got %h want 0", loData); else passCount++;
      checkCount++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", stall); else passCount++;
      checkCount++; if (reqReady !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", reqReady); else passCount++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult();
      exp_t e;
      vec_t v[2];
      v[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      v[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      for (int i = 0; i < 2; i++) begin
         scb.push_back('{1'b1, 1'b1, v[i].hi, v[i].lo, MUL_LAT});
         issueReq(v[i].op, v[i].a, v[i].b);
         checkCount++; if (issStall !== 1'b1) $display("[TB] FAIL mult%0d_stall_t got %b want 1", i, issStall); else passCount++;
         waitPulse(40);
         e = scb.pop_front();
         checkCount++; if (lat !== e.lat) $display("[TB] FAIL mult%0d_latency got %0d want %0d", i, lat, e.lat); else passCount++;
         checkCount++; if (stallCnt !== e.lat - 1) $display("[TB] FAIL mult%0d_stall_cycles got %0d want %0d", i, stallCnt, e.lat - 1); else passCount++;
         checkCount++; if (stallAtPulse !== 1'b0) $display("[TB] FAIL mult%0d_stall_pulse got %b want 0", i, stallAtPulse); else passCount++;
         checkCount++; if ({obsHw, obsLw} !== {e.hw, e.lw}) $display("[TB] FAIL mult%0d_strobes got %b%b want %b%b", i, obsHw, obsLw, e.hw, e.lw); else passCount++;
         checkCount++; if (obsHi !== e.hi) $display("[TB] FAIL mult%0d_hi got %h want %h", i, obsHi, e.hi); else passCount++;
         checkCount++; if (obsLo !== e.lo) $display("[TB] FAIL mult%0d_lo got %h want %h", i, obsLo, e.lo); else passCount++;
         @(negedge clk); #1;
         checkCount++; if ({hiWrite, loWrite} !== 2'b00) $display("[TB] FAIL mult%0d_one_cycle got %b%b want 00", i, hiWrite, loWrite); else passCount++;
      end
   endtask

   task automatic test_div();
      exp_t e;
      vec_t v[4];
      v[0] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      v[1] = '{3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF};
      v[2] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      v[3] = '{3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         scb.push_back('{1'b1, 1'b1, v[i].hi, v[i].lo, 33});
         issueReq(v[i].op, v[i].a, v[i].b);
         checkCount++; if (issStall !== 1'b1) $display("[TB] FAIL div%0d_stall_t got %b want 1", i, issStall); else passCount++;
         waitPulse(40);
         e = scb.pop_front();
         checkCount++; if (lat !== e.lat) $display("[TB] FAIL div%0d_latency got %0d want %0d", i, lat, e.lat); else passCount++;
         checkCount++; if (stallCnt !== 32) $display("[TB] FAIL div%0d_stall_cycles got %0d want 32", i, stallCnt); else passCount++;
         checkCount++; if ({obsHw, obsLw} !== 2'b11) $display("[TB] FAIL div%0d_strobes got %b%b want 11", i, obsHw, obsLw); else passCount++;
         checkCount++; if (obsHi !== e.hi) $display("[TB] FAIL div%0d_hi got %h want %h", i, obsHi, e.hi); else passCount++;
         checkCount++; if (obsLo !== e.lo) $display("[TB] FAIL div%0d_lo got %h want %h", i, obsLo, e.lo); else passCount++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      // MTHI, then MTLO presented in the MTHI pulse cycle.
      scb.push_back('{1'b1, 1'b0, 32'h1234_5678, 32'd0, 1});
      issueReq(3'd4, 32'h1234_5678, 32'd0);
      checkCount++; if (issStall !== 1'b0) $display("[TB] FAIL mthi_stall got %b want 0", issStall); else passCount++;
      scb.push_back('{1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, 1});
      issueReq(3'd5, 32'hCAFE_F00D, 32'd0);
      e = scb.pop_front();
      checkCount++; if ({obsHw, obsLw} !== {e.hw, e.lw}) $display("[TB] FAIL mthi_strobes got %b%b want %b%b", obsHw, obsLw, e.hw, e.lw); else passCount++;
      checkCount++; if (obsHi !== e.hi) $display("[TB] FAIL mthi_hi got %h want %h", obsHi, e.hi); else passCount++;
      checkCount++; if ({issStall, issReady} !== 2'b01) $display("[TB] FAIL mtlo_accept got stall,ready=%b%b want 01", issStall, issReady); else passCount++;
      waitPulse(5);
      e = scb.pop_front();
      checkCount++; if (lat !== e.lat) $display("[TB] FAIL mtlo_latency got %0d want %0d", lat, e.lat); else passCount++;
      checkCount++; if ({obsHw, obsLw} !== {e.hw, e.lw}) $display("[TB] FAIL mtlo_strobes got %b%b want %b%b", obsHw, obsLw, e.hw, e.lw); else passCount++;
      checkCount++; if (obsLo !== e.lo) $display("[TB] FAIL mtlo_lo got %h want %h", obsLo, e.lo); else passCount++;
      checkCount++; if (obsHi !== 32'h1234_5678) $display("[TB] FAIL hi_hold got %h want 12345678", obsHi); else passCount++;
      // MULT, then MULTU presented in the MULT pulse cycle.
      scb.push_back(model(3'd0, 32'd3, 32'hFFFF_FFFB));
      issueReq(3'd0, 32'd3, 32'hFFFF_FFFB);
      repeat (MUL_LAT - 1) begin @(negedge clk); reqValid = 1'b0; end
      scb.push_back(model(3'd1, 32'h0001_0000, 32'h0003_0000));
      issueReq(3'd1, 32'h0001_0000, 32'h0003_0000);
      e = scb.pop_front();
      checkCount++; if ({obsHw, obsLw, obsHi, obsLo} !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) $display("[TB] FAIL b2b_mult got %b%b %h %h want 11 ffffffff fffffff1", obsHw, obsLw, obsHi, obsLo); else passCount++;
      checkCount++; if ({issStall, issReady} !== 2'b11) $display("[TB] FAIL b2b_accept got stall,ready=%b%b want 11", issStall, issReady); else passCount++;
      waitPulse(40);
      e = scb.pop_front();
      checkCount++; if (lat !== MUL_LAT) $display("[TB] FAIL b2b_multu_latency got %0d want %0d", lat, MUL_LAT); else passCount++;
      checkCount++; if ({obsHi, obsLo} !== {32'h0000_0003, 32'h0000_0000}) $display("[TB] FAIL b2b_multu_data got %h %h want 00000003 00000000", obsHi, obsLo); else passCount++;
   endtask

   task automatic test_flush();
      exp_t e;
      int   strobes;
      strobes = 0;
      // Flush a divide ten cycles after acceptance.
      issueReq(3'd2, 32'd1000, 32'd3);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk); reqValid = 1'b0; #1;
         if (hiWrite || loWrite) strobes++;
      end
      @(negedge clk); flush = 1'b1; #1;
      checkCount++; if (stall !== 1'b1) $display("[TB] FAIL flush_stall_t10 got %b want 1", stall); else passCount++;
      @(negedge clk); flush = 1'b0; #1;
      checkCount++; if ({reqReady, stall} !== 2'b10) $display("[TB] FAIL flush_idle_t11 got ready,stall=%b%b want 10", reqReady, stall); else passCount++;
      // Flush in IDLE blocks acceptance; op 6 is ignored.
      @(negedge clk); reqValid = 1'b1; reqOp = 3'd0; reqA = 32'd9; reqB = 32'd9; flush = 1'b1; #1;
      checkCount++; if (stall !== 1'b0) $display("[TB] FAIL flush_idle_stall got %b want 0", stall); else passCount++;
      @(negedge clk); reqOp = 3'd6; flush = 1'b0; #1;
      checkCount++; if ({reqReady, stall} !== 2'b10) $display("[TB] FAIL op6_ignored got ready,stall=%b%b want 10", reqReady, stall); else passCount++;
      @(negedge clk); reqValid = 1'b0; #1;
      checkCount++; if (reqReady !== 1'b1) $display("[TB] FAIL op6_not_accepted got ready=%b want 1", reqReady); else passCount++;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (hiWrite || loWrite) strobes++;
      end
      checkCount++; if (strobes !== 0) $display("[TB] FAIL flush_no_pulse got %0d strobes want 0", strobes); else passCount++;
      // A MULT presented while a divide is busy is ignored.
      scb.push_back(model(3'd3, 32'd1000, 32'd7));
      issueReq(3'd3, 32'd1000, 32'd7);
      repeat (4) begin @(negedge clk); reqValid = 1'b0; end
      @(negedge clk); reqValid = 1'b1; reqOp = 3'd0; reqA = 32'd2; reqB = 32'd3; #1;
      checkCount++; if ({reqReady, stall} !== 2'b01) $display("[TB] FAIL busy_ready got ready,stall=%b%b want 01", reqReady, stall); else passCount++;
      repeat (2) @(negedge clk);
      waitPulse(40);
      e = scb.pop_front();
      checkCount++; if (lat !== e.lat - 7) $display("[TB] FAIL busy_div_latency got %0d want %0d", lat, e.lat - 7); else passCount++;
      checkCount++; if ({obsHi, obsLo} !== {32'd6, 32'd142}) $display("[TB] FAIL busy_div_data got %h %h want 00000006 0000008e", obsHi, obsLo); else passCount++;
      strobes = 0;
      for (int k = 0; k < MUL_LAT + 6; k++) begin
         @(negedge clk); #1;
         if (hiWrite || loWrite) strobes++;
      end
      checkCount++; if (strobes !== 0) $display("[TB] FAIL busy_extra_pulse got %0d strobes want 0", strobes); else passCount++;
   endtask

   task automatic test_reset_mid_mul();
      exp_t e;
      issueReq(3'd0, 32'h1111_1111, 32'h2222_2222);
      @(negedge clk); reqValid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkCount++; if ({hiData, loData} !== 64'd0) $display("[TB] FAIL async_reset_data got %h %h want 0 0", hiData, loData); else passCount++;
      checkCount++; if ({stall, reqReady, hiWrite, loWrite} !== 4'b0100) $display("[TB] FAIL async_reset_ctrl got %b want 0100", {stall, reqReady, hiWrite, loWrite}); else passCount++;
      @(negedge clk); reset = 1'b0;
      scb.push_back('{1'b1, 1'b1, 32'd0, 32'd42, MUL_LAT});
      issueReq(3'd0, 32'd6, 32'd7);
      waitPulse(40);
      e = scb.pop_front();
      checkCount++; if (lat !== e.lat) $display("[TB] FAIL post_reset_latency got %0d want %0d", lat, e.lat); else passCount++;
      checkCount++; if ({obsHi, obsLo} !== {e.hi, e.lo}) $display("[TB] FAIL post_reset_data got %h %h want %h %h", obsHi, obsLo, e.hi, e.lo); else passCount++;
   endtask

   task automatic test_random();
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         b  = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
         scb.push_back(model(op, a, b));
         issueReq(op, a, b);
         waitPulse(40);
         e = scb.pop_front();
         checkCount++; if (lat !== e.lat) $display("[TB] FAIL rand%0d_latency op=%0d got %0d want %0d", i, op, lat, e.lat); else passCount++;
         checkCount++; if ({obsHw, obsLw} !== {e.hw, e.lw}) $display("[TB] FAIL rand%0d_strobes op=%0d got %b%b want %b%b", i, op, obsHw, obsLw, e.hw, e.lw); else passCount++;
         if (e.hw) begin
            checkCount++; if (obsHi !== e.hi) $display("[TB] FAIL rand%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, obsHi, e.hi); else passCount++;
         end
         if (e.lw) begin
            checkCount++; if (obsLo !== e.lo) $display("[TB] FAIL rand%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, obsLo, e.lo); else passCount++;
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_flush();
      test_reset_mid_mul();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
